// File: rtl/vga_timing_gen.sv
// VGA timing generator and framebuffer scan-out: pixel-clock enable, h/v counters, RAM address
// generation with optional 2x replication, and sync/colour re-timed by the RAM read latency.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned IMG_W    = 320,
  parameter int unsigned IMG_H    = 240,
  parameter int unsigned IMG_X    = 0,
  parameter int unsigned IMG_Y    = 0,
  parameter int unsigned SCALE    = 1,
  parameter int unsigned RAM_LAT  = 1,
  parameter int unsigned PIX_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] ram_pixel,
  output logic [7:0]       row_read,
  output logic [8:0]       col_read,
  output logic             rd_en,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             h_free,
  output logic             v_free,
  output logic             frame_start,
  output logic             line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned PIPE    = RAM_LAT + 2;

  logic [DIV_W-1:0] div_q;
  logic [HC_W-1:0]  hc_q;
  logic [VC_W-1:0]  vc_q;
  logic             pix_ce, hc_last, vc_last;

  // Gated by rst so CLK_DIV=1 cannot strobe while held in reset.
  assign pix_ce  = !rst && (32'(div_q) == CLK_DIV - 1);
  assign hc_last = (32'(hc_q) == H_TOTAL - 1);
  assign vc_last = (32'(vc_q) == V_TOTAL - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
    end else begin
      div_q <= pix_ce ? '0 : div_q + 1'b1;
      if (pix_ce) begin
        hc_q <= hc_last ? '0 : hc_q + 1'b1;
        if (hc_last) vc_q <= vc_last ? '0 : vc_q + 1'b1;
      end
    end
  end

  logic [31:0] hx, vy;
  logic [8:0]  col_nxt;
  logic [7:0]  row_nxt;
  logic        in_win, hs_raw, vs_raw;

  // Offsets wrap to large values left of / above the image, so one compare covers both edges.
  always_comb begin
    hx      = 32'(hc_q) - IMG_X;
    vy      = 32'(vc_q) - IMG_Y;
    in_win  = (32'(hc_q) < H_ACTIVE) && (32'(vc_q) < V_ACTIVE) &&
              (hx < IMG_W * SCALE) && (vy < IMG_H * SCALE);
    col_nxt = 9'((SCALE == 2) ? (hx >> 1) : hx);
    row_nxt = 8'((SCALE == 2) ? (vy >> 1) : vy);
    hs_raw  = (32'(hc_q) >= H_ACTIVE + H_FP) && (32'(hc_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_raw  = (32'(vc_q) >= V_ACTIVE + V_FP) && (32'(vc_q) < V_ACTIVE + V_FP + V_SYNC);
  end

  assign h_free      = (32'(hc_q) < H_ACTIVE);
  assign v_free      = (32'(vc_q) < V_ACTIVE);
  assign line_start  = pix_ce && (hc_q == '0);
  assign frame_start = pix_ce && (hc_q == '0) && (vc_q == '0);

  logic [PIPE-1:0]  hs_p, vs_p;
  logic [RAM_LAT:0] win_p;
  logic [11:0]      rgb_q;

  // Stage 0 lines up with the address register; stage RAM_LAT with valid ram_pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_read <= '0;
      col_read <= '0;
      hs_p     <= '0;
      vs_p     <= '0;
      win_p    <= '0;
      rgb_q    <= '0;
    end else if (pix_ce) begin
      row_read <= in_win ? row_nxt : '0;
      col_read <= in_win ? col_nxt : '0;
      hs_p[0]  <= hs_raw;
      vs_p[0]  <= vs_raw;
      win_p[0] <= in_win;
      for (int k = 1; k < PIPE; k++) begin
        hs_p[k] <= hs_p[k-1];
        vs_p[k] <= vs_p[k-1];
      end
      for (int k = 1; k <= RAM_LAT; k++) win_p[k] <= win_p[k-1];
      rgb_q <= win_p[RAM_LAT] ? ram_pixel[11:0] : '0;
    end
  end

  assign rd_en  = pix_ce && win_p[0];
  assign vga_hs = hs_p[PIPE-1] ^ (HS_POL == 0);
  assign vga_vs = vs_p[PIPE-1] ^ (VS_POL == 0);
  assign vga_r  = rgb_q[11:8];
  assign vga_g  = rgb_q[7:4];
  assign vga_b  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: scaled-down timing, random RAM content, scoreboard queues for RAM
// reads and output pixels, and an asynchronous mid-line reset.
module tb_vga_timing_gen;

  localparam int D   = 3;
  localparam int HA  = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA  = 10, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int HPOL = 1, VPOL = 0;
  localparam int IW  = 5, IH = 6, IX = 3, IY = 1, SC = 2, LAT = 3;
  localparam int FRAME = HT * VT * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] ram_pixel;
  logic [7:0]  row_read;
  logic [8:0]  col_read;
  logic        rd_en, vga_hs, vga_vs, h_free, v_free, frame_start, line_start;
  logic [3:0]  vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .HS_POL(HPOL), .VS_POL(VPOL),
    .IMG_W(IW), .IMG_H(IH), .IMG_X(IX), .IMG_Y(IY), .SCALE(SC), .RAM_LAT(LAT), .PIX_W(12)
  ) dut (
    .clk(clk), .rst(rst), .ram_pixel(ram_pixel), .row_read(row_read), .col_read(col_read),
    .rd_en(rd_en), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .h_free(h_free), .v_free(v_free), .frame_start(frame_start),
    .line_start(line_start)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int col; } rd_t;
  typedef struct { logic [11:0] rgb; bit hs; bit vs; } pix_t;

  logic [11:0] mem [IH][IW];
  logic [11:0] ram_pipe [LAT];
  rd_t  exp_rd [$];
  pix_t exp_pix [$];
  int   t = 0;
  int   checks = 0;
  int   errors = 0;

  assign ram_pixel = ram_pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  function automatic bit in_img(input int hc, input int vc);
    return hc < HA && vc < VA && hc >= IX && hc < IX + IW * SC && vc >= IY && vc < IY + IH * SC;
  endfunction

  // Reference: scan position is pure arithmetic on clocks elapsed since reset release.
  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      exp_rd.delete();
      exp_pix.delete();
    end else begin
      if (t % D == D - 1) begin
        int p, hc, vc;
        pix_t e;
        p  = t / D;
        hc = p % HT;
        vc = (p / HT) % VT;
        e.hs  = hc >= HA + HFP && hc < HA + HFP + HSW;
        e.vs  = vc >= VA + VFP && vc < VA + VFP + VSW;
        e.rgb = 12'h000;
        if (in_img(hc, vc)) begin
          exp_rd.push_back('{row: (vc - IY) / SC, col: (hc - IX) / SC});
          e.rgb = mem[(vc - IY) / SC][(hc - IX) / SC];
        end
        exp_pix.push_back(e);
        // RAM model: synchronous read with LAT pixel ticks of latency
        ram_pipe[0] <= (int'(row_read) < IH && int'(col_read) < IW) ?
                       mem[int'(row_read)][int'(col_read)] : 12'h000;
        for (int k = 1; k < LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
      end
      t = t + 1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rd_en", rd_en, 0);
      chk("rst_addr", {row_read, col_read}, 0);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      chk("rst_hs", vga_hs, !HPOL);
      chk("rst_vs", vga_vs, !VPOL);
      chk("rst_strobes", {frame_start, line_start}, 0);
    end else begin
      bit pce;
      int p, hc, vc;
      pce = (t % D == D - 1);
      p   = t / D;
      hc  = p % HT;
      vc  = (p / HT) % VT;
      chk("frame_start", frame_start, pce && hc == 0 && vc == 0);
      chk("line_start", line_start, pce && hc == 0);
      chk("h_free", h_free, hc < HA);
      chk("v_free", v_free, vc < VA);
      if (!pce) chk("rd_en_off_tick", rd_en, 0);
      else begin
        if (exp_rd.size() > 0) begin
          rd_t r;
          r = exp_rd.pop_front();
          chk("rd_en", rd_en, 1);
          chk("row_read", row_read, r.row);
          chk("col_read", col_read, r.col);
        end else begin
          chk("rd_en_outside", rd_en, 0);
          chk("addr_outside", {row_read, col_read}, 0);
        end
        if (p < LAT + 2) begin
          chk("fill_rgb", {vga_r, vga_g, vga_b}, 0);
          chk("fill_hs", vga_hs, !HPOL);
          chk("fill_vs", vga_vs, !VPOL);
        end else if (exp_pix.size() == 0) begin
          chk("pix_queue_empty", 0, 1);
        end else begin
          pix_t e;
          e = exp_pix.pop_front();
          chk("rgb", {vga_r, vga_g, vga_b}, e.rgb);
          chk("hs", vga_hs, e.hs ? HPOL : !HPOL);
          chk("vs", vga_vs, e.vs ? VPOL : !VPOL);
        end
      end
    end
  end

  task automatic fill_mem();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) mem[r][c] = 12'($urandom);
  endtask

  initial begin
    fill_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // land the reset partway through a line, off the clock edge
    repeat (2 * FRAME + 5 * HT * D + 10 * D + $urandom_range(0, D - 1)) @(posedge clk);
    #($urandom_range(1, 8)) rst = 1'b1;
    #1;
    chk("async_rst_hs", vga_hs, !HPOL);
    chk("async_rst_vs", vga_vs, !VPOL);
    chk("async_rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("async_rst_rd_en", rd_en, 0);
    chk("async_rst_addr", {row_read, col_read}, 0);
    fill_mem();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (FRAME + 3 * HT * D) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
